// File: rtl/jtvigil_pkg.sv
// Shared definitions for the jtvigil graphics ROM slots.
// Holds the fetch FSM encoding, SDRAM geometry and ROM region bases.
package jtvigil_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 16;

    localparam logic [SDRAM_AW-1:0] SCR1_OFFSET = 22'h00000;
    localparam logic [SDRAM_AW-1:0] SCR2_OFFSET = 22'h10000;
    localparam logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h20000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } romslot_state_t;

endpackage

// File: rtl/jtvigil_gfx_romslot_if.sv
// Client fetch port plus SDRAM slot port of one tile-ROM responder.
// The slave modport is the responder, the master modport its surroundings.
interface jtvigil_gfx_romslot_if #(
    parameter int AW    = 17,
    parameter int SDRAW = 22
);
    logic             rom_cs;
    logic [AW-1:0]    rom_addr;
    logic [31:0]      rom_data;
    logic             rom_ok;
    logic             sdr_req;
    logic [SDRAW-1:0] sdr_addr;
    logic             sdr_ack;
    logic             sdr_dst;
    logic [15:0]      sdr_din;
    logic             sdr_rdy;

    modport slave (
        input  rom_cs, rom_addr, sdr_ack, sdr_dst, sdr_din, sdr_rdy,
        output rom_data, rom_ok, sdr_req, sdr_addr
    );

    modport master (
        output rom_cs, rom_addr, sdr_ack, sdr_dst, sdr_din, sdr_rdy,
        input  rom_data, rom_ok, sdr_req, sdr_addr
    );
endinterface

// File: rtl/jtvigil_romcache2.sv
// Two-entry tag/data store with a one-bit LRU victim pointer.
// Lookups are combinational; a fill lands on the LRU entry next cycle.
module jtvigil_romcache2 #(
    parameter int TW = 16
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          lookup_en,
    input  logic [TW-1:0] lookup_tag,
    output logic          hit,
    output logic [31:0]   hit_data,
    input  logic          fill_en,
    input  logic [TW-1:0] fill_tag,
    input  logic [31:0]   fill_data
);

    logic [1:0]    valid;
    logic [TW-1:0] tags [2];
    logic [31:0]   data [2];
    logic          lru;
    logic [1:0]    match;
    logic          hit_way;

    assign match[0] = valid[0] && (tags[0] == lookup_tag);
    assign match[1] = valid[1] && (tags[1] == lookup_tag);
    assign hit      = lookup_en && (|match);
    assign hit_way  = ~match[0];
    assign hit_data = data[hit_way];

    // A fill always wins over a same-cycle hit for the LRU update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            lru   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else if (fill_en) begin
            valid[lru] <= 1'b1;
            tags[lru]  <= fill_tag;
            data[lru]  <= fill_data;
            lru        <= ~lru;
        end else if (hit) begin
            lru <= ~hit_way;
        end
    end

endmodule

// File: rtl/jtvigil_gfx_romslot.sv
// Tile-ROM responder: cached 32-bit fetches backed by 2-word SDRAM bursts.
// The FSM and SDRAM handshake live here; storage lives in the cache.
module jtvigil_gfx_romslot
    import jtvigil_pkg::*;
#(
    parameter int               AW     = 17,
    parameter int               SDRAW  = SDRAM_AW,
    parameter logic [SDRAW-1:0] OFFSET = SDRAW'(SCR1_OFFSET)
) (
    input  logic rst,
    input  logic clk,
    jtvigil_gfx_romslot_if.slave bus
);

    localparam int TW = AW - 1;

    romslot_state_t   state;
    romslot_state_t   state_nx;
    logic [TW-1:0]    tag_in;
    logic [TW-1:0]    tag_q;
    logic [15:0]      lo_q;
    logic             half_q;
    logic             req_q;
    logic [SDRAW-1:0] addr_q;
    logic [31:0]      last_q;
    logic             hit;
    logic [31:0]      hit_data;
    logic             miss;
    logic             fill;
    logic             unused;

    assign tag_in = bus.rom_addr[AW-1:1];
    assign miss   = bus.rom_cs && !hit;
    assign unused = ^{bus.sdr_rdy, bus.rom_addr[0]};

    jtvigil_romcache2 #(.TW(TW)) u_cache (
        .rst        (rst),
        .clk        (clk),
        .lookup_en  (bus.rom_cs),
        .lookup_tag (tag_in),
        .hit        (hit),
        .hit_data   (hit_data),
        .fill_en    (fill),
        .fill_tag   (tag_q),
        .fill_data  ({bus.sdr_din, lo_q})
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fill     = 1'b0;
        unique case (state)
            IDLE: if (miss) state_nx = REQ;
            REQ:  if (bus.sdr_ack) state_nx = DATA;
            DATA: begin
                if (bus.sdr_dst && half_q) begin
                    fill     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only IDLE launches requests, so an address change mid-fetch waits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q  <= '0;
            lo_q   <= '0;
            half_q <= 1'b0;
            req_q  <= 1'b0;
            addr_q <= '0;
            last_q <= '0;
        end else begin
            if (hit) last_q <= hit_data;
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        req_q  <= 1'b1;
                        addr_q <= OFFSET + SDRAW'({tag_in, 1'b0});
                        tag_q  <= tag_in;
                        half_q <= 1'b0;
                    end
                end
                REQ: if (bus.sdr_ack) req_q <= 1'b0;
                DATA: begin
                    if (bus.sdr_dst) begin
                        if (!half_q) lo_q <= bus.sdr_din;
                        half_q <= ~half_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_ok   = hit;
    assign bus.rom_data = hit ? hit_data : last_q;
    assign bus.sdr_req  = req_q;
    assign bus.sdr_addr = addr_q;

endmodule

// File: tb/tb_jtvigil_gfx_romslot.sv
// Directed bench for jtvigil_gfx_romslot with a queue-based scoreboard.
// Drivers push expectations; a negedge monitor pops them on DUT outputs.
module tb_jtvigil_gfx_romslot;

    localparam int BIG = 32'h7fffffff;

    typedef struct { int sel; logic [21:0] addr; } aexp_t;
    typedef struct { int sel; logic [31:0] data; } dexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jtvigil_gfx_romslot_if #(.AW(17), .SDRAW(22)) b0 ();
    jtvigil_gfx_romslot_if #(.AW(17), .SDRAW(22)) b1 ();

    jtvigil_gfx_romslot #(.AW(17), .SDRAW(22), .OFFSET(22'h0)) u0 (
        .rst (rst),
        .clk (clk),
        .bus (b0.slave)
    );

    jtvigil_gfx_romslot #(.AW(17), .SDRAW(22), .OFFSET(22'h10000)) u1 (
        .rst (rst),
        .clk (clk),
        .bus (b1.slave)
    );

    logic        cs  [2];
    logic [16:0] ra  [2];
    logic        ack [2];
    logic        dst [2];
    logic        rdy [2];
    logic [15:0] din [2];
    logic        ok  [2];
    logic        req [2];
    logic [21:0] sa  [2];
    logic [31:0] rd  [2];

    assign b0.rom_cs   = cs[0];
    assign b0.rom_addr = ra[0];
    assign b0.sdr_ack  = ack[0];
    assign b0.sdr_dst  = dst[0];
    assign b0.sdr_din  = din[0];
    assign b0.sdr_rdy  = rdy[0];
    assign b1.rom_cs   = cs[1];
    assign b1.rom_addr = ra[1];
    assign b1.sdr_ack  = ack[1];
    assign b1.sdr_dst  = dst[1];
    assign b1.sdr_din  = din[1];
    assign b1.sdr_rdy  = rdy[1];
    assign ok[0]  = b0.rom_ok;
    assign req[0] = b0.sdr_req;
    assign sa[0]  = b0.sdr_addr;
    assign rd[0]  = b0.rom_data;
    assign ok[1]  = b1.rom_ok;
    assign req[1] = b1.sdr_req;
    assign sa[1]  = b1.sdr_addr;
    assign rd[1]  = b1.rom_data;

    aexp_t       qa [$];
    dexp_t       qd [$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          min_ok   = 0;
    logic        prev_req [2];
    logic        prev_ok  [2];
    logic [21:0] cur_addr [2];

    always @(posedge clk) cyc++;

    task automatic chk(input bit cond, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk(!req[i] && !ok[i], "reset_req_ok",
                    {30'd0, req[i], ok[i]}, 32'd0);
                chk(rd[i] == 32'd0 && sa[i] == 22'd0, "reset_data_addr",
                    rd[i] | 32'(sa[i]), 32'd0);
            end else begin
                if (req[i] && !prev_req[i]) begin
                    if (qa.size() == 0 || qa[0].sel != i) begin
                        chk(1'b0, "unexpected_sdr_req", 32'(sa[i]), 32'd0);
                    end else begin
                        aexp_t a;
                        a = qa.pop_front();
                        cur_addr[i] = a.addr;
                        chk(sa[i] == a.addr, "sdr_addr", 32'(sa[i]), 32'(a.addr));
                    end
                end else if (req[i] && prev_req[i]) begin
                    chk(sa[i] == cur_addr[i], "sdr_addr_hold",
                        32'(sa[i]), 32'(cur_addr[i]));
                end
                if (ok[i] && !prev_ok[i]) begin
                    if (qd.size() == 0 || qd[0].sel != i) begin
                        chk(1'b0, "unexpected_rom_ok", rd[i], 32'd0);
                    end else begin
                        dexp_t d;
                        d = qd.pop_front();
                        chk(rd[i] == d.data, "rom_data", rd[i], d.data);
                        chk(cyc >= min_ok, "rom_ok_latency", 32'(cyc), 32'(min_ok));
                    end
                end
            end
            prev_req[i] = req[i];
            prev_ok[i]  = ok[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int s, output bit seen);
        int n;
        n = 0;
        while (!req[s] && n < 50) begin
            tick();
            n++;
        end
        seen = req[s];
        if (!seen) chk(1'b0, "sdr_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int s, input logic [15:0] lo, input logic [15:0] hi,
                         input int delay, input bit swap, input logic [16:0] swap_addr,
                         input bit last);
        bit seen;
        wait_req(s, seen);
        if (seen) begin
            repeat (delay) tick();
            ack[s] = 1'b1;
            tick();
            ack[s] = 1'b0;
            if (swap) ra[s] = swap_addr;
            dst[s] = 1'b1;
            din[s] = lo;
            tick();
            din[s] = hi;
            rdy[s] = 1'b1;
            if (last) min_ok = cyc + 1;
            tick();
            dst[s] = 1'b0;
            rdy[s] = 1'b0;
        end
    endtask

    task automatic access_miss(input int s, input logic [16:0] addr,
                               input logic [15:0] lo, input logic [15:0] hi,
                               input logic [21:0] exp_sa, input int delay);
        qa.push_back('{s, exp_sa});
        qd.push_back('{s, {hi, lo}});
        min_ok = BIG;
        ra[s] = addr;
        cs[s] = 1'b1;
        serve(s, lo, hi, delay, 1'b0, 17'd0, 1'b1);
        tick();
        tick();
        cs[s] = 1'b0;
        tick();
    endtask

    task automatic access_hit(input int s, input logic [16:0] addr,
                              input logic [31:0] data);
        qd.push_back('{s, data});
        min_ok = 0;
        ra[s] = addr;
        cs[s] = 1'b1;
        tick();
        cs[s] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            cs[i] = 1'b0; ra[i] = '0; ack[i] = 1'b0;
            dst[i] = 1'b0; rdy[i] = 1'b0; din[i] = '0;
            prev_req[i] = 1'b0; prev_ok[i] = 1'b0; cur_addr[i] = '0;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // 1: cold miss
        access_miss(0, 17'h000A0, 16'h1234, 16'hABCD, 22'h0000A0, 0);
        // 2: odd word address of same fetch hits at once
        access_hit(0, 17'h000A1, 32'hABCD1234);
        // 3: LRU eviction
        access_miss(0, 17'h000B0, 16'h5B00, 16'h5B01, 22'h0000B0, 1);
        access_miss(0, 17'h000C0, 16'hC0C0, 16'hC1C1, 22'h0000C0, 0);
        access_hit(0, 17'h000B0, 32'h5B015B00);
        access_miss(0, 17'h000A0, 16'h1111, 16'h2222, 22'h0000A0, 2);

        // 4: address moves to 0x0D0 while 0x0C0 burst is in flight
        qa.push_back('{0, 22'h0000C0});
        qa.push_back('{0, 22'h0000D0});
        qd.push_back('{0, 32'hDEADD00D});
        min_ok = BIG;
        ra[0] = 17'h000C0;
        cs[0] = 1'b1;
        serve(0, 16'hC0C0, 16'hC1C1, 0, 1'b1, 17'h000D0, 1'b0);
        serve(0, 16'hD00D, 16'hDEAD, 0, 1'b0, 17'd0, 1'b1);
        tick();
        tick();
        cs[0] = 1'b0;
        tick();
        access_hit(0, 17'h000C0, 32'hC1C1C0C0);

        // 5: reset between ack and the first burst word
        qa.push_back('{0, 22'h0000E0});
        ra[0] = 17'h000E0;
        cs[0] = 1'b1;
        wait_req(0, seen);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        rst = 1'b1;
        cs[0] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        dst[0] = 1'b1;
        din[0] = 16'h5555;
        tick();
        din[0] = 16'h6666;
        rdy[0] = 1'b1;
        tick();
        dst[0] = 1'b0;
        rdy[0] = 1'b0;
        tick();
        access_miss(0, 17'h000E0, 16'h0E0E, 16'hE0E0, 22'h0000E0, 0);
        access_miss(0, 17'h000A0, 16'h3333, 16'h4444, 22'h0000A0, 0);

        // 6: offset wraps into upper region, long ack stall
        access_miss(1, 17'h1FFFF, 16'h7777, 16'h8888, 22'h2FFFE, 20);
        access_hit(1, 17'h1FFFE, 32'h88887777);

        repeat (4) tick();
        chk(qa.size() == 0, "addr_queue_drained", 32'(qa.size()), 32'd0);
        chk(qd.size() == 0, "data_queue_drained", 32'(qd.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
